// File: rtl/vae_decoder_seq.sv
`default_nettype none
// ============================================================================
// vae_decoder_seq : 2-latent, 9-pixel sequential VAE decoder using one shared
//                   multiplier and a piecewise-linear sigmoid (Q8.12 data).
// Revision: 1.0
// ============================================================================
module vae_decoder_seq #(
  parameter int FRAC_BITS = 12,
  parameter logic [179:0] W1 = {20'h096AE, 20'h2CE81, 20'h0A82D, 20'h2D5EF, 20'hD656D,
                                20'h2CAC8, 20'h09DCB, 20'h2D0AB, 20'h0A1C4},
  parameter logic [179:0] W2 = {20'h14663, 20'hF197E, 20'h171F5, 20'hF2E17, 20'h15EA0,
                                20'hF12E7, 20'h15212, 20'hF1FBB, 20'h165EE},
  parameter logic [179:0] B  = {20'h225A6, 20'hFDB31, 20'h21ADF, 20'hFD764, 20'h00CBD,
                                20'hFDCBE, 20'h222D7, 20'hFDA10, 20'h21DD0}
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [19:0] z1,
  input  logic [19:0] z2,
  output logic        prob_valid,
  output logic [3:0]  prob_idx,
  output logic [19:0] prob_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [8:0]  out_pix
);

  typedef enum logic [1:0] {IDLE = 2'd0, COMPUTE = 2'd1, DONE = 2'd2} state_t;

  state_t             r_state, w_state_next;
  logic [3:0]         r_idx;
  logic [1:0]         r_phase;
  logic signed [23:0] r_acc;
  logic signed [19:0] r_z1, r_z2;
  logic [8:0]         r_pix;

  logic signed [19:0] w_w1 [9];
  logic signed [19:0] w_w2 [9];
  logic signed [19:0] w_b  [9];

  genvar g;
  generate
    for (g = 0; g < 9; g++) begin : g_unpack
      assign w_w1[g] = W1[20*g +: 20];
      assign w_w2[g] = W2[20*g +: 20];
      assign w_b[g]  = B[20*g +: 20];
    end
  endgenerate

  logic signed [19:0] w_wsel, w_zsel;
  logic signed [39:0] w_prod, w_shift;
  logic signed [23:0] w_term, w_base, w_acc_next;
  logic signed [24:0] w_sum;
  logic signed [19:0] w_x;
  logic [19:0]        w_abs, w_ymag, w_y;

  assign w_wsel  = (r_phase == 2'd0) ? w_w1[r_idx] : w_w2[r_idx];
  assign w_zsel  = (r_phase == 2'd0) ? r_z1 : r_z2;
  assign w_prod  = w_wsel * w_zsel;
  assign w_shift = w_prod >>> FRAC_BITS;
  assign w_base  = (r_phase == 2'd0) ? {{4{w_b[r_idx][19]}}, w_b[r_idx]} : r_acc;
  assign w_sum   = {w_base[23], w_base} + {w_term[23], w_term};

  // Shifted product and running sum clamp at the 24-bit rails instead of
  // wrapping, so extreme weight/latent pairs still saturate the sigmoid.
  always_comb begin
    w_term = w_shift[23:0];
    if (w_shift > 40'sd8388607)
      w_term = 24'sh7FFFFF;
    else if (w_shift < -40'sd8388608)
      w_term = 24'sh800000;

    w_acc_next = w_sum[23:0];
    if (w_sum[24] != w_sum[23])
      w_acc_next = w_sum[24] ? 24'sh800000 : 24'sh7FFFFF;
  end

  always_comb begin
    w_x = r_acc[19:0];
    if (r_acc > 24'sd524287)
      w_x = 20'sh7FFFF;
    else if (r_acc < -24'sd524288)
      w_x = 20'sh80000;

    w_abs = w_x[19] ? (20'd0 - w_x) : w_x;

    if (w_abs >= 20'd20480)
      w_ymag = 20'd4096;
    else if (w_abs >= 20'd9728)
      w_ymag = (w_abs >> 5) + 20'd3456;
    else if (w_abs >= 20'd4096)
      w_ymag = (w_abs >> 3) + 20'd2560;
    else
      w_ymag = (w_abs >> 2) + 20'd2048;

    w_y = w_x[19] ? (20'd4096 - w_ymag) : w_ymag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          w_state_next = COMPUTE;
      end
      COMPUTE: begin
        if (r_phase == 2'd2 && r_idx == 4'd8)
          w_state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready)
          w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= 4'd0;
      r_phase    <= 2'd0;
      r_acc      <= 24'sd0;
      r_z1       <= 20'sd0;
      r_z2       <= 20'sd0;
      r_pix      <= 9'd0;
      prob_valid <= 1'b0;
      prob_idx   <= 4'd0;
      prob_data  <= 20'd0;
    end else begin
      prob_valid <= 1'b0;
      if (r_state == IDLE && in_valid) begin
        r_z1    <= z1;
        r_z2    <= z2;
        r_idx   <= 4'd0;
        r_phase <= 2'd0;
        r_pix   <= 9'd0;
      end else if (r_state == COMPUTE) begin
        case (r_phase)
          2'd0, 2'd1: begin
            r_acc   <= w_acc_next;
            r_phase <= r_phase + 2'd1;
          end
          default: begin
            r_pix[r_idx] <= (w_y >= 20'd2048);
            prob_valid   <= 1'b1;
            prob_idx     <= r_idx;
            prob_data    <= w_y;
            r_phase      <= 2'd0;
            r_idx        <= (r_idx == 4'd8) ? 4'd0 : r_idx + 4'd1;
          end
        endcase
      end
    end
  end

  assign out_pix = r_pix;

endmodule
`default_nettype wire

// File: tb/tb_vae_decoder_seq.sv
`default_nettype none
// ============================================================================
// tb_vae_decoder_seq : directed bench over six parameterisations sharing stimulus.
// Revision: 1.0
// ============================================================================
module tb_vae_decoder_seq;

  localparam int ND = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [19:0] z1, z2;

  logic        pv [ND];
  logic [3:0]  pi [ND];
  logic [19:0] pd [ND];
  logic        ov [ND];
  logic        ir [ND];
  logic [8:0]  px [ND];

  int exp_p [ND][9];
  int exp_x [ND];
  bit en    [ND];

  int ncomp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  // 0: all zero, 1: alternating bias, 2: W1=1.0, 3: W1=max, 4: W2=1.0, 5: default
  vae_decoder_seq #(.W1(180'd0), .W2(180'd0), .B(180'd0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .z1(z1), .z2(z2),
    .prob_valid(pv[0]), .prob_idx(pi[0]), .prob_data(pd[0]), .out_valid(ov[0]),
    .out_ready(out_ready), .out_pix(px[0]));

  vae_decoder_seq #(.W1(180'd0), .W2(180'd0),
    .B({20'h01000, 20'hFF000, 20'h01000, 20'hFF000, 20'h01000,
        20'hFF000, 20'h01000, 20'hFF000, 20'h01000})) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .z1(z1), .z2(z2),
    .prob_valid(pv[1]), .prob_idx(pi[1]), .prob_data(pd[1]), .out_valid(ov[1]),
    .out_ready(out_ready), .out_pix(px[1]));

  vae_decoder_seq #(.W1({9{20'h01000}}), .W2(180'd0), .B(180'd0)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .z1(z1), .z2(z2),
    .prob_valid(pv[2]), .prob_idx(pi[2]), .prob_data(pd[2]), .out_valid(ov[2]),
    .out_ready(out_ready), .out_pix(px[2]));

  vae_decoder_seq #(.W1({9{20'h7FFFF}}), .W2(180'd0), .B(180'd0)) u_d3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[3]), .z1(z1), .z2(z2),
    .prob_valid(pv[3]), .prob_idx(pi[3]), .prob_data(pd[3]), .out_valid(ov[3]),
    .out_ready(out_ready), .out_pix(px[3]));

  vae_decoder_seq #(.W1(180'd0), .W2({9{20'h01000}}), .B(180'd0)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[4]), .z1(z1), .z2(z2),
    .prob_valid(pv[4]), .prob_idx(pi[4]), .prob_data(pd[4]), .out_valid(ov[4]),
    .out_ready(out_ready), .out_pix(px[4]));

  vae_decoder_seq u_d5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[5]), .z1(z1), .z2(z2),
    .prob_valid(pv[5]), .prob_idx(pi[5]), .prob_data(pd[5]), .out_valid(ov[5]),
    .out_ready(out_ready), .out_pix(px[5]));

  task automatic chk(input string tag, input int obs, input int expv);
    ncomp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic set_alt(input int d, input int ev, input int od, input int pix);
    for (int k = 0; k < 9; k++) exp_p[d][k] = (k % 2 == 0) ? ev : od;
    exp_x[d] = pix;
    en[d]    = 1'b1;
  endtask

  // Accept one latent pair, scramble the inputs, then check every strobe and
  // the exact cycle out_valid rises. Leaves the block in DONE.
  task automatic run_frame(input logic [19:0] a, input logic [19:0] b);
    in_valid = 1'b1;
    z1 = a;
    z2 = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    z1 = a ^ 20'h5A5A5;
    z2 = b ^ 20'hA5A5A;
    chk("in_ready_busy", int'(ir[0]), 0);
    for (int k = 0; k < 9; k++) begin
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("pv_gap_k%0d", k), int'(pv[0]), 0);
      if (k > 0) begin
        chk($sformatf("pi_hold_k%0d", k), int'(pi[1]), k - 1);
        chk($sformatf("pd_hold_k%0d", k), int'(pd[1]), exp_p[1][k-1]);
      end
      if (k == 8) chk("ov_early", int'(ov[0]), 0);
      @(posedge clk);
      #1;
      for (int d = 0; d < ND; d++) begin
        if (en[d]) begin
          chk($sformatf("pv_d%0d_k%0d", d, k), int'(pv[d]), 1);
          chk($sformatf("pi_d%0d_k%0d", d, k), int'(pi[d]), k);
          chk($sformatf("pd_d%0d_k%0d", d, k), int'(pd[d]), exp_p[d][k]);
          if (k == 8) begin
            chk($sformatf("ov_d%0d", d), int'(ov[d]), 1);
            chk($sformatf("pix_d%0d", d), int'(px[d]), exp_x[d]);
          end
        end
      end
    end
  endtask

  task automatic release_frame();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("ir_after_d%0d", d), int'(ir[d]), 1);
      chk($sformatf("ov_after_d%0d", d), int'(ov[d]), 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    z1 = 20'd0;
    z2 = 20'd0;
    for (int d = 0; d < ND; d++) en[d] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("rst_ir_d%0d", d), int'(ir[d]), 1);
      chk($sformatf("rst_ov_d%0d", d), int'(ov[d]), 0);
      chk($sformatf("rst_pv_d%0d", d), int'(pv[d]), 0);
      chk($sformatf("rst_pd_d%0d", d), int'(pd[d]), 0);
      chk($sformatf("rst_px_d%0d", d), int'(px[d]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Frame A: zero latents
    set_alt(0, 2048, 2048, 'h1FF);
    set_alt(1, 3072, 1024, 'h155);
    set_alt(2, 2048, 2048, 'h1FF);
    set_alt(3, 2048, 2048, 'h1FF);
    set_alt(4, 2048, 2048, 'h1FF);
    exp_p[5] = '{4096, 322, 4096, 408, 2863, 316, 4096, 359, 4096};
    exp_x[5] = 'h155;
    en[5] = 1'b1;
    run_frame(20'h00000, 20'h00000);

    // Consumer stalls while a new pair is offered
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      @(posedge clk);
      #1;
      chk($sformatf("bp_ov_%0d", i), int'(ov[1]), 1);
      chk($sformatf("bp_ir_%0d", i), int'(ir[1]), 0);
      chk($sformatf("bp_px_%0d", i), int'(px[1]), 'h155);
      chk($sformatf("bp_pv_%0d", i), int'(pv[1]), 0);
    end
    in_valid = 1'b0;
    release_frame();
    en[5] = 1'b0;

    // Frame B: z1=+2.0, z2=-2.0
    set_alt(2, 3584, 3584, 'h1FF);
    set_alt(3, 4096, 4096, 'h1FF);
    set_alt(4, 512, 512, 'h000);
    run_frame(20'h02000, 20'hFE000);
    release_frame();

    // Frame C: z1=-2.0, z2=+2.0
    set_alt(2, 512, 512, 'h000);
    set_alt(3, 0, 0, 'h000);
    set_alt(4, 3584, 3584, 'h1FF);
    run_frame(20'hFE000, 20'h02000);
    release_frame();

    // Frame D: z1 at positive rail
    set_alt(2, 4096, 4096, 'h1FF);
    set_alt(3, 4096, 4096, 'h1FF);
    set_alt(4, 2048, 2048, 'h1FF);
    run_frame(20'h7FFFF, 20'h00000);
    release_frame();

    // Frame E: z1 at negative rail
    set_alt(2, 0, 0, 'h000);
    set_alt(3, 0, 0, 'h000);
    run_frame(20'h80000, 20'h00000);
    release_frame();

    // Reset asserted while idx=4 is in flight
    in_valid = 1'b1;
    z1 = 20'h0;
    z2 = 20'h0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (13) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("mrst_pv_d%0d", d), int'(pv[d]), 0);
      chk($sformatf("mrst_pi_d%0d", d), int'(pi[d]), 0);
      chk($sformatf("mrst_pd_d%0d", d), int'(pd[d]), 0);
      chk($sformatf("mrst_ov_d%0d", d), int'(ov[d]), 0);
      chk($sformatf("mrst_ir_d%0d", d), int'(ir[d]), 1);
      chk($sformatf("mrst_px_d%0d", d), int'(px[d]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full frame after reset
    set_alt(2, 2048, 2048, 'h1FF);
    set_alt(3, 2048, 2048, 'h1FF);
    exp_p[5] = '{4096, 322, 4096, 408, 2863, 316, 4096, 359, 4096};
    exp_x[5] = 'h155;
    en[5] = 1'b1;
    run_frame(20'h00000, 20'h00000);
    release_frame();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
`default_nettype wire
